// File: rtl/quad_horner_ctrl_pkg.sv
// quad_horner_ctrl_pkg: Q7.8 fixed-point type, symmetric limits, FSM states and sign helpers
package quad_horner_ctrl_pkg;
  localparam int T1_W = 16;
  localparam int T1_F = 8;
  typedef logic signed [T1_W-1:0] t1_fxd_t;
  localparam t1_fxd_t T1_MAX = t1_fxd_t'((1 << (T1_W-1)) - 1);
  localparam t1_fxd_t T1_MINS = -T1_MAX;
  localparam t1_fxd_t T1_MINV = t1_fxd_t'(1 << (T1_W-1));
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL1 = 3'd1;
  localparam logic [2:0] ADD1 = 3'd2;
  localparam logic [2:0] MUL2 = 3'd3;
  localparam logic [2:0] ADD2 = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  function automatic t1_fxd_t clampsym(t1_fxd_t v);
    return v == T1_MINV ? T1_MINS : v;
  endfunction
  function automatic t1_fxd_t negsym(t1_fxd_t v);
    return v == T1_MINV ? T1_MAX : -v;
  endfunction
  // magnitude fits T1_W-1 bits because the most-negative value saturates to T1_MAX
  function automatic logic [T1_W-2:0] abssat(t1_fxd_t v);
    return (T1_W-1)'(v[T1_W-1] ? negsym(v) : v);
  endfunction
endpackage

// File: rtl/quad_horner_ctrl_if.sv
// quad_horner_ctrl_if: job input (in_valid/in_ready, a,b,c,x) and result output (out_valid/out_ready, y, ovf)
interface quad_horner_ctrl_if;
  import quad_horner_ctrl_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, ovf;
  t1_fxd_t a, b, c, x, y;
  modport master(output in_valid, a, b, c, x, out_ready, input in_ready, out_valid, y, ovf);
  modport slave(input in_valid, a, b, c, x, out_ready, output in_ready, out_valid, y, ovf);
endinterface

// File: rtl/quad_horner_ctrl_mul.sv
// quad_horner_ctrl_mul: signed x1 times unsigned x2 in Q7.8; rounds toward zero, keeps low T1_W bits
// ports: x1 signed operand, x2 magnitude operand, p product
module quad_horner_ctrl_mul
  import quad_horner_ctrl_pkg::*;
(
  input  t1_fxd_t          x1,
  input  logic [T1_W-1:0]  x2,
  output t1_fxd_t          p
);
  logic signed [2*T1_W:0] full;
  logic [2*T1_W:0] mag;
  t1_fxd_t q;
  assign full = $signed({{(T1_W+1){x1[T1_W-1]}}, x1}) * $signed({{(T1_W+1){1'b0}}, x2});
  assign mag = full[2*T1_W] ? -full : full;
  assign q = t1_fxd_t'(mag >> T1_F);
  assign p = full[2*T1_W] ? -q : q;
endmodule

// File: rtl/quad_horner_ctrl_sat_add.sv
// quad_horner_ctrl_sat_add: T1_W+1 bit add, clamps (SAT_EN=1) or wraps outside the symmetric range
// ports: a, b addends; sum result; ovf result left [T1_MINS, T1_MAX]
module quad_horner_ctrl_sat_add
  import quad_horner_ctrl_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  t1_fxd_t a,
  input  t1_fxd_t b,
  output t1_fxd_t sum,
  output logic    ovf
);
  localparam logic signed [T1_W:0] HI = {T1_MAX[T1_W-1], T1_MAX};
  localparam logic signed [T1_W:0] LO = {T1_MINS[T1_W-1], T1_MINS};
  logic signed [T1_W:0] s;
  assign s = $signed({a[T1_W-1], a}) + $signed({b[T1_W-1], b});
  assign ovf = s > HI || s < LO;
  assign sum = !(ovf && SAT_EN) ? s[T1_W-1:0] : s[T1_W] ? T1_MINS : T1_MAX;
endmodule

// File: rtl/quad_horner_ctrl.sv
// quad_horner_ctrl: y = (a*x + b)*x + c with one shared multiplier and one shared adder
// ports: clk, rst_n (async active-low), bus (slave: in_valid/in_ready, a,b,c,x, out_valid/out_ready, y, ovf)
module quad_horner_ctrl
  import quad_horner_ctrl_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  quad_horner_ctrl_if.slave bus
);
  logic [2:0] state;
  t1_fxd_t acc, prod, rb, rc, y_r, mul_p, add_a, add_s;
  logic [T1_W-2:0] mx;
  logic sx, ovf_r, vld_r, add_ovf;
  quad_horner_ctrl_mul u_mul (.x1(acc), .x2({1'b0, mx}), .p(mul_p));
  // the multiplier only sees |x|, so the sign of x is reapplied to each product here
  assign add_a = sx ? negsym(prod) : prod;
  quad_horner_ctrl_sat_add #(.SAT_EN(SAT_EN)) u_add (
    .a(add_a), .b(state == ADD1 ? rb : rc), .sum(add_s), .ovf(add_ovf)
  );
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = vld_r;
  assign bus.y = y_r;
  assign bus.ovf = ovf_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      prod <= '0;
      rb <= '0;
      rc <= '0;
      y_r <= '0;
      mx <= '0;
      sx <= 1'b0;
      ovf_r <= 1'b0;
      vld_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          rb <= bus.b;
          rc <= bus.c;
          sx <= bus.x[T1_W-1];
          mx <= abssat(bus.x);
          acc <= clampsym(bus.a);
          ovf_r <= 1'b0;
          state <= MUL1;
        end
        MUL1: begin
          prod <= mul_p;
          state <= ADD1;
        end
        ADD1: begin
          acc <= add_s;
          ovf_r <= ovf_r | add_ovf;
          state <= MUL2;
        end
        MUL2: begin
          prod <= mul_p;
          state <= ADD2;
        end
        ADD2: begin
          y_r <= add_s;
          ovf_r <= ovf_r | add_ovf;
          vld_r <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          vld_r <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
